// File: rtl/wb_port_arbiter_if.sv
// Bus bundle for the register-file write-port arbiter: writeback, LLU,
// debug and register-file signals. The testbench drives the master side.
interface wb_port_arbiter_if #(
  parameter int NB_REG  = 32,
  parameter int NB_ADDR = 5
);
  logic               i_wb_regwrite;
  logic [NB_ADDR-1:0] i_wb_addr;
  logic [NB_REG-1:0]  i_wb_data;
  logic               i_llu_valid;
  logic [NB_ADDR-1:0] i_llu_addr;
  logic [NB_REG-1:0]  i_llu_data;
  logic               o_llu_ready;
  logic               i_halted;
  logic               i_dbg_we;
  logic [NB_ADDR-1:0] i_dbg_addr;
  logic [NB_REG-1:0]  i_dbg_data;
  logic               o_dbg_ack;
  logic               o_rf_we;
  logic [NB_ADDR-1:0] o_rf_addr;
  logic [NB_REG-1:0]  o_rf_data;
  logic               o_stall_req;
  logic [1:0]         o_fifo_count;

  modport master (
    output i_wb_regwrite, i_wb_addr, i_wb_data,
    output i_llu_valid, i_llu_addr, i_llu_data,
    output i_halted, i_dbg_we, i_dbg_addr, i_dbg_data,
    input  o_llu_ready, o_dbg_ack, o_rf_we, o_rf_addr, o_rf_data,
    input  o_stall_req, o_fifo_count
  );

  modport slave (
    input  i_wb_regwrite, i_wb_addr, i_wb_data,
    input  i_llu_valid, i_llu_addr, i_llu_data,
    input  i_halted, i_dbg_we, i_dbg_addr, i_dbg_data,
    output o_llu_ready, o_dbg_ack, o_rf_we, o_rf_addr, o_rf_data,
    output o_stall_req, o_fifo_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. Priority: writeback, then the head of a
// 2-entry LLU result FIFO, then debug writes (only while halted). A head that
// keeps losing to writeback raises a registered stall request.
module wb_port_arbiter #(
  parameter int NB_REG       = 32,
  parameter int NB_ADDR      = 5,
  parameter int STARVE_LIMIT = 4
) (
  input logic               i_clk,
  input logic               i_rst_n,
  wb_port_arbiter_if.slave  bus
);
  logic [NB_ADDR-1:0] mem_addr_q [2];
  logic [NB_ADDR-1:0] mem_addr_d [2];
  logic [NB_REG-1:0]  mem_data_q [2];
  logic [NB_REG-1:0]  mem_data_d [2];
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [1:0]         count_q, count_d;
  logic [3:0]         starve_q, starve_d;
  logic               stall_q, stall_d;
  logic               dbg_ack_q, dbg_ack_d;
  logic               rf_we_q, rf_we_d;
  logic [NB_ADDR-1:0] rf_addr_q, rf_addr_d;
  logic [NB_REG-1:0]  rf_data_q, rf_data_d;

  logic wb_win_s, head_win_s, dbg_win_s, push_s, llu_ready_s;

  assign llu_ready_s      = (count_q != 2'd2) && i_rst_n;
  assign bus.o_llu_ready  = llu_ready_s;
  assign bus.o_fifo_count = count_q;
  assign bus.o_stall_req  = stall_q;
  assign bus.o_dbg_ack    = dbg_ack_q;
  assign bus.o_rf_we      = rf_we_q;
  assign bus.o_rf_addr    = rf_addr_q;
  assign bus.o_rf_data    = rf_data_q;

  // Arbitration, FIFO bookkeeping and starvation tracking for the next edge.
  always_comb begin
    wb_win_s   = bus.i_wb_regwrite && (bus.i_wb_addr != '0);
    head_win_s = !wb_win_s && (count_q != 2'd0);
    dbg_win_s  = !wb_win_s && !head_win_s && bus.i_dbg_we && bus.i_halted && !dbg_ack_q;
    // Results for r0 are accepted but never stored.
    push_s     = bus.i_llu_valid && llu_ready_s && (bus.i_llu_addr != '0);

    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (push_s) begin
      mem_addr_d[wr_ptr_q] = bus.i_llu_addr;
      mem_data_d[wr_ptr_q] = bus.i_llu_data;
      wr_ptr_d             = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (head_win_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, head_win_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (wb_win_s) begin
      rf_we_d   = 1'b1;
      rf_addr_d = bus.i_wb_addr;
      rf_data_d = bus.i_wb_data;
    end else if (head_win_s) begin
      rf_we_d   = 1'b1;
      rf_addr_d = mem_addr_q[rd_ptr_q];
      rf_data_d = mem_data_q[rd_ptr_q];
    end else if (dbg_win_s && (bus.i_dbg_addr != '0)) begin
      rf_we_d   = 1'b1;
      rf_addr_d = bus.i_dbg_addr;
      rf_data_d = bus.i_dbg_data;
    end else begin
      rf_we_d = 1'b0;
    end
    dbg_ack_d = dbg_win_s;

    // Only a non-empty FIFO losing to writeback counts as starvation.
    if ((count_q == 2'd0) || head_win_s) begin
      starve_d = 4'd0;
    end else if (starve_q != 4'd15) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
    if (head_win_s) begin
      stall_d = 1'b0;
    end else if (starve_d >= 4'(STARVE_LIMIT)) begin
      stall_d = 1'b1;
    end else begin
      stall_d = stall_q;
    end
  end

  // State and registered outputs, with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mem_addr_q[0] <= '0;
      mem_addr_q[1] <= '0;
      mem_data_q[0] <= '0;
      mem_data_q[1] <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      starve_q      <= 4'd0;
      stall_q       <= 1'b0;
      dbg_ack_q     <= 1'b0;
      rf_we_q       <= 1'b0;
      rf_addr_q     <= '0;
      rf_data_q     <= '0;
    end else begin
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      dbg_ack_q  <= dbg_ack_d;
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
    end
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port and shares it between three requesters:
  - the pipeline writeback stage (mux output plus RegWrite/destination);
  - results from the long-latency multiply/divide unit (LLU);
  - the debug unit, which writes registers while the core is halted.
- Buffers LLU results in a 2-entry FIFO and requests a pipeline stall when an LLU result starves.
- Sits between the writeback stage and the register file.

Parameters:
NB_REG, 32, data width of register-file write data.
NB_ADDR, 5, register address width.
STARVE_LIMIT, 4, number of consecutive cycles the FIFO head may lose arbitration before o_stall_req asserts (valid range 1..15).

Ports:
i_clk  input  1  clock.
i_rst_n  input  1  reset. One clock; reset is synchronous and active-low.
i_wb_regwrite  input  1  writeback stage requests a register write this cycle.
i_wb_addr  input  NB_ADDR  writeback destination register.
i_wb_data  input  NB_REG  writeback data (output of the writeback mux).
i_llu_valid  input  1  LLU result valid.
i_llu_addr  input  NB_ADDR  LLU destination register.
i_llu_data  input  NB_REG  LLU result.
o_llu_ready  output  1  FIFO can accept an LLU result.
i_halted  input  1  core halted; debug writes are permitted.
i_dbg_we  input  1  debug write request; held until acked.
i_dbg_addr  input  NB_ADDR  debug destination register.
i_dbg_data  input  NB_REG  debug data.
o_dbg_ack  output  1  one-cycle pulse: the debug write was granted.
o_rf_we  output  1  register-file write enable (registered).
o_rf_addr  output  NB_ADDR  register-file write address (registered).
o_rf_data  output  NB_REG  register-file write data (registered).
o_stall_req  output  1  request that the pipeline insert bubbles (registered).
o_fifo_count  output  2  LLU FIFO occupancy, 0..2.

Behaviour:
Reset (i_rst_n=0 at a rising edge):
- o_rf_we, o_rf_addr, o_rf_data, o_stall_req, o_dbg_ack, o_fifo_count all go to 0.
- FIFO is emptied; starvation counter cleared.
- Reset mid-transaction discards buffered LLU results.
- o_llu_ready is combinational: o_llu_ready = (count<2) and i_rst_n; it reads 1 in the first cycle after reset.

LLU push:
- A push happens when i_llu_valid and o_llu_ready are both 1 at a clock edge.
- A push to address 0 is accepted and discarded, and does not occupy the FIFO.

Arbitration (evaluated combinationally each cycle; the winner is registered onto o_rf_* at the next edge, so latency is 1 cycle):
1. WB wins if i_wb_regwrite=1 and i_wb_addr!=0. WB is never back-pressured.
2. Otherwise the FIFO head wins if the FIFO is non-empty. It pops at that edge.
3. Otherwise debug wins if i_dbg_we=1, i_halted=1, and o_dbg_ack=0 in the current cycle. o_dbg_ack pulses the next cycle. A debug write to address 0 is still acked, but o_rf_we stays 0.
- If there is no winner, o_rf_we=0; o_rf_addr and o_rf_data hold their previous values.
- WB requests with addr 0 are treated as no request.

Simultaneous push and pop:
- Allowed in the same cycle.
- When the FIFO is full, o_llu_ready=0 that cycle even if a pop occurs (no bypass).
- When the FIFO is empty, a push is not forwarded to the port in the same cycle; it is written at the earliest 2 cycles after the push.

Starvation control:
- Counter increments each cycle the FIFO is non-empty and the head loses to WB.
- Counter clears on a pop or when the FIFO is empty.
- When the counter reaches STARVE_LIMIT, o_stall_req is set at the next edge.
- o_stall_req clears at the edge where the head pops.
- While stalled, the pipeline supplies i_wb_regwrite=0, so the head wins under the normal priority.

Ordering:
- LLU results are written in FIFO order.
- If WB and the FIFO head target the same register in one cycle, WB is written first; the head is written later and is the final value.

Test Plan:
- Reset: hold i_rst_n=0 for 3 cycles with all requests active -> o_rf_we=0, o_stall_req=0, o_fifo_count=0, o_dbg_ack=0. Release -> o_llu_ready=1.
- WB only: i_wb_regwrite=1, addr=5, data=0xDEADBEEF -> next cycle o_rf_we=1, o_rf_addr=5, o_rf_data=0xDEADBEEF. With addr=0 -> o_rf_we=0.
- Contention: WB writes every cycle; LLU pushes (7,0x11) then (8,0x22) -> o_fifo_count=2 and o_llu_ready=0. After 4 lost cycles o_stall_req=1. WB drops -> the port writes r7=0x11 then r8=0x22 on consecutive cycles. o_stall_req clears after the r7 pop.
- Simultaneous push/pop at count=1: -> count stays 1, and data order is preserved.
- Debug: i_halted=0, i_dbg_we=1 (r3, 0x55) -> no ack. Raise i_halted -> 1-cycle o_dbg_ack and o_rf_we for r3=0x55. Debug is blocked for a cycle while the FIFO is non-empty.
- LLU push to r0: valid with addr=0 -> accepted, count stays 0, no register-file write.
